syn_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 31 +++
 rtl/syn_fifo_if.sv | 35 +++
 rtl/syn_fifo_mem.sv | 30 +++
 rtl/syn_fifo.sv | 112 +++++++++++
 tb/tb_syn_fifo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fifo_pkg                                                         |
// | Brief   : Shared FIFO defaults, clog2 helper and parameter legality check. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  localparam int c_WIDTH_DEFAULT = 8;
  localparam int c_ADDR_DEFAULT  = 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit levels_ok(input int addr, input int af, input int ae);
    int d;
    d = 1 << addr;
    return (addr >= 1) && (addr <= 10) && (af >= 1) && (af <= d) && (ae >= 0) && (ae <= d - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/syn_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : syn_fifo_if                                                    |
// | Brief     : Write/read handshake, status and error signals of syn_fifo.    |
// | Rev       : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface syn_fifo_if #(
  parameter int WIDTH_FIFO = 8,
  parameter int ADDR_FIFO  = 3
);
  logic                  wen;
  logic [WIDTH_FIFO-1:0] wdata;
  logic                  ren;
  logic                  err_clr;
  logic [WIDTH_FIFO-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_FIFO:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wen, wdata, ren, err_clr,
    input  rdata, rvalid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wen, wdata, ren, err_clr,
    output rdata, rvalid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/syn_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : syn_fifo_mem                                                      |
// | Brief  : DEPTH x WIDTH storage, one sync write port, one async read port.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module syn_fifo_mem #(
  parameter int WIDTH_FIFO = 8,
  parameter int ADDR_FIFO  = 3
) (
  input  wire logic                  clk,
  input  wire logic                  wen,
  input  wire logic [ADDR_FIFO-1:0]  waddr,
  input  wire logic [WIDTH_FIFO-1:0] wdata,
  input  wire logic [ADDR_FIFO-1:0]  raddr,
  output logic      [WIDTH_FIFO-1:0] rdata
);
  localparam int DEPTH_FIFO = 1 << ADDR_FIFO;

  logic [WIDTH_FIFO-1:0] r_mem [DEPTH_FIFO];

  always_ff @(posedge clk) begin
    if (wen) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/syn_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : syn_fifo                                                          |
// | Brief  : Single-clock FIFO with registered level flags, sticky errors and  |
// |          selectable standard / first-word-fall-through read.               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module syn_fifo
  import fifo_pkg::*;
#(
  parameter int DLY        = 1,
  parameter int WIDTH_FIFO = c_WIDTH_DEFAULT,
  parameter int ADDR_FIFO  = c_ADDR_DEFAULT,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (1 << ADDR_FIFO) - 2,
  parameter int AE_LEVEL   = 1
) (
  input wire logic   clk,
  input wire logic   rst_n,
  syn_fifo_if.slave  bus
);
  localparam int DEPTH_FIFO = 1 << ADDR_FIFO;
  localparam logic [ADDR_FIFO:0] c_DEPTH = (ADDR_FIFO + 1)'(DEPTH_FIFO);
  localparam logic [ADDR_FIFO:0] c_AF    = (ADDR_FIFO + 1)'(AF_LEVEL);
  localparam logic [ADDR_FIFO:0] c_AE    = (ADDR_FIFO + 1)'(AE_LEVEL);

  if (!levels_ok(ADDR_FIFO, AF_LEVEL, AE_LEVEL) || clog2(DEPTH_FIFO) != ADDR_FIFO || DLY < 0) begin : g_param_chk
    $error("syn_fifo: illegal ADDR_FIFO / AF_LEVEL / AE_LEVEL / DLY setting");
  end

  logic [ADDR_FIFO-1:0]  r_wptr;
  logic [ADDR_FIFO-1:0]  r_rptr;
  logic [ADDR_FIFO:0]    r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_ae;
  logic                  r_af;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_FIFO:0]    w_count_nxt;
  logic [WIDTH_FIFO-1:0] w_mem_rd;

  // Acceptance uses only registered flags, so wen/ren never reach a flag combinationally.
  always_comb begin
    w_wr_ok     = bus.wen & ~r_full;
    w_rd_ok     = bus.ren & ~r_empty;
    w_count_nxt = r_count + {{ADDR_FIFO{1'b0}}, w_wr_ok} - {{ADDR_FIFO{1'b0}}, w_rd_ok};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + ADDR_FIFO'(1);
      if (w_rd_ok) r_rptr <= r_rptr + ADDR_FIFO'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_DEPTH);
      r_ae    <= (w_count_nxt <= c_AE);
      r_af    <= (w_count_nxt >= c_AF);
      // A new error event wins over a coincident clear.
      r_ovf   <= (bus.wen & r_full)  | (r_ovf & ~bus.err_clr);
      r_unf   <= (bus.ren & r_empty) | (r_unf & ~bus.err_clr);
    end
  end

  syn_fifo_mem #(
    .WIDTH_FIFO (WIDTH_FIFO),
    .ADDR_FIFO  (ADDR_FIFO)
  ) u_mem (
    .clk   (clk),
    .wen   (w_wr_ok),
    .waddr (r_wptr),
    .wdata (bus.wdata),
    .raddr (r_rptr),
    .rdata (w_mem_rd)
  );

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = r_empty ? '0 : w_mem_rd;
    assign bus.rvalid = ~r_empty;
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bus.rdata  <= '0;
        bus.rvalid <= 1'b0;
      end else begin
        bus.rvalid <= w_rd_ok;
        if (w_rd_ok) bus.rdata <= w_mem_rd;
      end
    end
  end

  assign bus.count        = r_count;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_ae;
  assign bus.almost_full  = r_af;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_syn_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_syn_fifo                                                       |
// | Brief  : Standard and FWFT instances driven in lockstep, checked against a |
// |          queue model every cycle plus directed literal expectations.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_syn_fifo;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syn_fifo_if #(.WIDTH_FIFO(8), .ADDR_FIFO(3)) if_s ();
  syn_fifo_if #(.WIDTH_FIFO(8), .ADDR_FIFO(3)) if_f ();

  syn_fifo #(.WIDTH_FIFO(8), .ADDR_FIFO(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1))
    u_std (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  syn_fifo #(.WIDTH_FIFO(8), .ADDR_FIFO(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit         m_live   = 1'b0;
  bit         m_ovf    = 1'b0;
  bit         m_unf    = 1'b0;
  bit         m_rvalid = 1'b0;
  logic [7:0] m_rdata  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit wen, input logic [7:0] wd, input bit ren, input bit ec);
    if_s.wen = wen; if_s.wdata = wd; if_s.ren = ren; if_s.err_clr = ec;
    if_f.wen = wen; if_f.wdata = wd; if_f.ren = ren; if_f.err_clr = ec;
  endtask

  // Model: the FIFO content is a queue; flags and errors follow directly from its size.
  task automatic model_step();
    bit full_now, empty_now, wr, rd;
    logic [7:0] popped;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = 8'h00; m_live = 1;
    end else begin
      full_now  = (q.size() == 8);
      empty_now = (q.size() == 0);
      wr = if_s.wen && !full_now;
      rd = if_s.ren && !empty_now;
      m_ovf = (if_s.wen && full_now) || (m_ovf && !if_s.err_clr);
      m_unf = (if_s.ren && empty_now) || (m_unf && !if_s.err_clr);
      m_rvalid = rd;
      if (rd) begin
        popped  = q.pop_front();
        m_rdata = popped;
      end
      if (wr) q.push_back(if_s.wdata);
    end
  endtask

  task automatic check_all();
    int n;
    if (!m_live) return;
    n = q.size();
    chk("std_count", 32'(if_s.count), 32'(n));
    chk("std_empty", 32'(if_s.empty), 32'(n == 0));
    chk("std_full", 32'(if_s.full), 32'(n == 8));
    chk("std_aempty", 32'(if_s.almost_empty), 32'(n <= 1));
    chk("std_afull", 32'(if_s.almost_full), 32'(n >= 6));
    chk("std_ovf", 32'(if_s.overflow), 32'(m_ovf));
    chk("std_unf", 32'(if_s.underflow), 32'(m_unf));
    chk("std_rvalid", 32'(if_s.rvalid), 32'(m_rvalid));
    chk("std_rdata", 32'(if_s.rdata), 32'(m_rdata));
    chk("fwft_count", 32'(if_f.count), 32'(n));
    chk("fwft_aempty", 32'(if_f.almost_empty), 32'(n <= 1));
    chk("fwft_afull", 32'(if_f.almost_full), 32'(n >= 6));
    chk("fwft_ovf", 32'(if_f.overflow), 32'(m_ovf));
    chk("fwft_unf", 32'(if_f.underflow), 32'(m_unf));
    chk("fwft_rvalid", 32'(if_f.rvalid), 32'(n != 0));
    chk("fwft_rdata", 32'(if_f.rdata), (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int pw, pr;
    set_in(0, 8'h00, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    chk("t0_count", 32'(if_s.count), 32'd0);
    chk("t0_empty", 32'(if_s.empty), 32'd1);
    chk("t0_aempty", 32'(if_s.almost_empty), 32'd1);
    chk("t0_rvalid", 32'(if_s.rvalid), 32'd0);
    rst_n = 1'b1;

    // 1: fill with 0x10..0x17, then overflow attempt
    for (int i = 0; i < 8; i++) begin
      set_in(1, 8'(8'h10 + i), 0, 0);
      tick();
      chk("t1_count", 32'(if_s.count), 32'(i + 1));
      chk("t1_aempty", 32'(if_s.almost_empty), 32'(i == 0));
      chk("t1_afull", 32'(if_s.almost_full), 32'(i >= 5));
    end
    chk("t1_full", 32'(if_s.full), 32'd1);
    set_in(1, 8'h99, 0, 0); tick();
    chk("t1_ovf", 32'(if_s.overflow), 32'd1);
    chk("t1_count8", 32'(if_s.count), 32'd8);

    // 2: drain in order, then underflow attempt
    for (int i = 0; i < 8; i++) begin
      set_in(0, 8'h00, 1, 0);
      tick();
      chk("t2_rdata", 32'(if_s.rdata), 32'(8'h10 + i));
      chk("t2_rvalid", 32'(if_s.rvalid), 32'd1);
    end
    chk("t2_empty", 32'(if_s.empty), 32'd1);
    tick();
    chk("t2_unf", 32'(if_s.underflow), 32'd1);
    chk("t2_hold", 32'(if_s.rdata), 32'h17);
    chk("t2_rvalid0", 32'(if_s.rvalid), 32'd0);

    // 3: full with simultaneous write and read
    set_in(0, 8'h00, 0, 1); tick();
    chk("t3_clr", 32'(if_s.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 8'(8'h10 + i), 0, 0); tick();
    end
    set_in(1, 8'hAA, 1, 0); tick();
    chk("t3_count", 32'(if_s.count), 32'd7);
    chk("t3_ovf", 32'(if_s.overflow), 32'd1);

    // 4: hold at 4 entries with concurrent traffic
    for (int i = 0; i < 3; i++) begin
      set_in(0, 8'h00, 1, 0); tick();
    end
    chk("t4_start", 32'(if_s.count), 32'd4);
    for (int i = 0; i < 20; i++) begin
      set_in(1, 8'(8'h40 + i), 1, 0); tick();
      chk("t4_count", 32'(if_s.count), 32'd4);
    end

    // 5: FWFT visibility
    for (int i = 0; i < 4; i++) begin
      set_in(0, 8'h00, 1, 0); tick();
    end
    set_in(0, 8'h00, 0, 0); tick();
    set_in(1, 8'h5A, 0, 0); tick();
    set_in(0, 8'h00, 0, 0);
    chk("t5_rdata", 32'(if_f.rdata), 32'h5A);
    chk("t5_rvalid", 32'(if_f.rvalid), 32'd1);
    set_in(0, 8'h00, 1, 0); tick();
    chk("t5_empty", 32'(if_f.empty), 32'd1);
    chk("t5_rdata0", 32'(if_f.rdata), 32'h00);

    // 6: reset overrides write; set beats clear
    for (int i = 0; i < 5; i++) begin
      set_in(1, 8'(8'h60 + i), 0, 0); tick();
    end
    chk("t6_count5", 32'(if_s.count), 32'd5);
    chk("t6_ovf_pre", 32'(if_s.overflow), 32'd1);
    rst_n = 1'b0;
    set_in(1, 8'hEE, 0, 0); tick();
    chk("t6_count0", 32'(if_s.count), 32'd0);
    chk("t6_empty", 32'(if_s.empty), 32'd1);
    chk("t6_ovf0", 32'(if_s.overflow), 32'd0);
    rst_n = 1'b1;
    set_in(0, 8'h00, 0, 0); tick();
    chk("t6_nowrite", 32'(if_s.empty), 32'd1);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 8'(8'h70 + i), 0, 0); tick();
    end
    set_in(1, 8'h00, 0, 1); tick();
    chk("t6_setwins", 32'(if_s.overflow), 32'd1);
    set_in(0, 8'h00, 0, 1); tick();
    chk("t6_clr", 32'(if_s.overflow), 32'd0);

    // Random traffic with drifting write/read bias
    pw = 50; pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        pw = $urandom_range(90, 10);
        pr = $urandom_range(90, 10);
      end
      rst_n = ($urandom_range(255) != 0);
      set_in($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr, $urandom_range(15) == 0);
      tick();
    end
    rst_n = 1'b1;
    set_in(0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
